pwm_decoder: RTL and testbench

PWM_DECODER -- requirements
Module: pwm_decoder

---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_sync.sv | 68 ++++++
 rtl/pwm_decoder.sv | 156 +++++++++++++++
 tb/tb_pwm_decoder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared declarations for the PWM decoder slice.
//   C_PWM_LEVEL_WIDTH : default duty level width W (frame length 2**W cycles)
//   pwm_state_e       : decoder FSM states
//     S_ALIGN - searching for the frame start (rising edge or idle timeout)
//     S_RUN   - counting high samples inside a phase-aligned window
// -----------------------------------------------------------------------------
package pwm_pkg;

  localparam int C_PWM_LEVEL_WIDTH = 8;

  typedef enum logic {
    S_ALIGN = 1'b0,
    S_RUN   = 1'b1
  } pwm_state_e;

endpackage

// File: rtl/pwm_sync.sv
// -----------------------------------------------------------------------------
// pwm_sync
// Brings the asynchronous PWM input into the clk domain through a 2-flop
// synchronizer. When PWM_DECODER_GLITCH_FILTER_EN is defined, a filter follows
// the synchronizer: its output only takes a new value once three consecutive
// synchronized samples agree, which rejects 1- and 2-cycle glitches and adds
// 2 cycles of latency. Without the macro the synchronizer output is passed
// straight through and no filter flops exist.
//
// Ports
//   clk     in  : clock, rising edge
//   rstb    in  : synchronous active-low reset, clears every flop
//   i_pwm   in  : raw asynchronous PWM waveform
//   o_pwm_s out : synchronized (and optionally filtered) PWM sample
// -----------------------------------------------------------------------------
module pwm_sync (
  input  logic clk,
  input  logic rstb,
  input  logic i_pwm,
  output logic o_pwm_s
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_pwm;
      r_s2 <= r_s1;
    end
  end

`ifdef PWM_DECODER_GLITCH_FILTER_EN
  // r_h1/r_h2 hold the two previous synchronized samples; the filtered value
  // follows r_s2 only when it matches both, otherwise it holds (r_f).
  logic r_h1;
  logic r_h2;
  logic r_f;
  logic w_f;

  always_comb begin
    w_f = r_f;
    if ((r_s2 == r_h1) && (r_s2 == r_h2)) begin
      w_f = r_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_h1 <= 1'b0;
      r_h2 <= 1'b0;
      r_f  <= 1'b0;
    end else begin
      r_h1 <= r_s2;
      r_h2 <= r_h1;
      r_f  <= w_f;
    end
  end

  assign o_pwm_s = w_f;
`else
  assign o_pwm_s = r_s2;
`endif

endmodule

// File: rtl/pwm_decoder.sv
// -----------------------------------------------------------------------------
// pwm_decoder
// Recovers the duty level of a PWM waveform whose period is N = 2**W clk
// cycles. The decoder aligns its counting window to the rising edge of the
// waveform (or to an idle timeout for constant input), sums the high samples
// over one window and reports min(sum, N-1).
//
// Optional feature: define PWM_DECODER_GLITCH_FILTER_EN to insert a glitch
// filter after the synchronizer (see pwm_sync).
//
// Parameters
//   C_CLK_FRQ     : clk frequency in Hz, informational only
//   C_LEVEL_WIDTH : level width W
//
// Ports
//   clk         in  : clock, rising edge
//   rstb        in  : synchronous active-low reset
//   pwm_in      in  : asynchronous PWM waveform
//   level       out : last decoded level, held between updates
//   valid       out : one-cycle strobe, high in the cycle level takes a new
//                     value; there is no ready/backpressure, a consumer must
//                     capture level while valid is high
//   locked      out : window phase-aligned to the input frame
//   o_dbg_state out : FSM state, 0 = S_ALIGN, 1 = S_RUN
// -----------------------------------------------------------------------------
module pwm_decoder
  import pwm_pkg::*;
#(
  parameter int C_CLK_FRQ     = 100000000,
  parameter int C_LEVEL_WIDTH = C_PWM_LEVEL_WIDTH
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     pwm_in,
  output logic [C_LEVEL_WIDTH-1:0] level,
  output logic                     valid,
  output logic                     locked,
  output logic                     o_dbg_state
);

  localparam int W = C_LEVEL_WIDTH;
  // All-ones is both the last window index and the saturated level (N-1).
  localparam logic [W-1:0] C_LAST = '1;

  if (C_CLK_FRQ <= 0) begin : g_bad_clk
    $error("pwm_decoder: C_CLK_FRQ must be positive");
  end

  logic w_s;
  logic w_rise;
  logic r_prev;

  pwm_state_e r_state;
  pwm_state_e w_state_nxt;
  logic [W-1:0] r_idle;
  logic [W-1:0] w_idle_nxt;
  logic [W-1:0] r_idx;
  logic [W-1:0] w_idx_nxt;
  logic [W:0]   r_sum;
  logic [W:0]   w_sum_nxt;
  logic [W:0]   w_total;
  logic [W-1:0] r_level;
  logic [W-1:0] w_level_nxt;
  logic         r_valid;
  logic         w_valid_nxt;
  logic         r_locked;
  logic         w_locked_nxt;

  pwm_sync u_sync (
    .clk     (clk),
    .rstb    (rstb),
    .i_pwm   (pwm_in),
    .o_pwm_s (w_s)
  );

  assign w_rise  = w_s & ~r_prev;
  // Sum including the current sample; at most N, so it fits in W+1 bits.
  assign w_total = r_sum + {{W{1'b0}}, w_s};

  always_comb begin
    w_state_nxt  = r_state;
    w_idle_nxt   = r_idle;
    w_idx_nxt    = r_idx;
    w_sum_nxt    = r_sum;
    w_level_nxt  = r_level;
    w_valid_nxt  = 1'b0;
    w_locked_nxt = r_locked;
    case (r_state)
      S_ALIGN: begin
        if (w_rise) begin
          // The edge sample itself is index 0 of the first window.
          w_state_nxt = S_RUN;
          w_idle_nxt  = '0;
          w_idx_nxt   = W'(1);
          w_sum_nxt   = (W+1)'(1);
        end else if (r_idle == C_LAST) begin
          // N edge-free cycles: constant input, start at the next sample.
          w_state_nxt = S_RUN;
          w_idle_nxt  = '0;
          w_idx_nxt   = '0;
          w_sum_nxt   = '0;
        end else begin
          w_idle_nxt = r_idle + W'(1);
        end
      end
      S_RUN: begin
        if (w_rise && (r_idx != '0)) begin
          // Edge out of place: drop the partial window and realign on it.
          w_locked_nxt = 1'b0;
          w_idx_nxt    = W'(1);
          w_sum_nxt    = (W+1)'(1);
        end else if (r_idx == C_LAST) begin
          w_idx_nxt    = '0;
          w_sum_nxt    = '0;
          w_valid_nxt  = 1'b1;
          w_locked_nxt = 1'b1;
          w_level_nxt  = w_total[W] ? C_LAST : w_total[W-1:0];
        end else begin
          w_idx_nxt = r_idx + W'(1);
          w_sum_nxt = w_total;
        end
      end
      default: begin
        w_state_nxt = S_ALIGN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state  <= S_ALIGN;
      r_prev   <= 1'b0;
      r_idle   <= '0;
      r_idx    <= '0;
      r_sum    <= '0;
      r_level  <= '0;
      r_valid  <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_prev   <= w_s;
      r_idle   <= w_idle_nxt;
      r_idx    <= w_idx_nxt;
      r_sum    <= w_sum_nxt;
      r_level  <= w_level_nxt;
      r_valid  <= w_valid_nxt;
      r_locked <= w_locked_nxt;
    end
  end

  assign level       = r_level;
  assign valid       = r_valid;
  assign locked      = r_locked;
  assign o_dbg_state = (r_state == S_RUN);

endmodule

// File: tb/tb_pwm_decoder.sv
module tb_pwm_decoder;

  localparam int W = 8;
  localparam int N = 256;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
  localparam int C_FILT_LAT = 2;
`else
  localparam int C_FILT_LAT = 0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic         clk    = 1'b0;
  logic         rstb   = 1'b0;
  logic         pwm_in = 1'b0;
  logic [W-1:0] level;
  logic         valid;
  logic         locked;
  logic         dbg_state;

  always #5 clk = ~clk;

  pwm_decoder #(
    .C_CLK_FRQ     (100000000),
    .C_LEVEL_WIDTH (W)
  ) dut (
    .clk         (clk),
    .rstb        (rstb),
    .pwm_in      (pwm_in),
    .level       (level),
    .valid       (valid),
    .locked      (locked),
    .o_dbg_state (dbg_state)
  );

  // ---------------- PWM encoder driver ----------------
  int ph         = 0;
  int drv_hi     = 0;   // high cycles per frame; 256 = constant high
  bit glitch_en  = 1'b0;
  int shift_cnt  = 0;   // bumped by main to request a +10 phase jump
  int shift_done = 0;

  initial begin
    forever begin
      @(negedge clk);
      if ((shift_done != shift_cnt) && (ph == 150)) begin
        ph         = ph + 10;
        shift_done = shift_cnt;
      end
      pwm_in = ((ph < drv_hi) || (glitch_en && ((ph == 100) || (ph == 180)))) ? 1'b1 : 1'b0;
      ph = (ph + 1) % N;
    end
  end

  // ---------------- behavioural reference model ----------------
  // Effective sample = input delayed by the synchronizer (and filter).
  // Alignment: aligned mode collects samples of one frame in win_q; the
  // number of samples already collected is the window position.
  bit           m_p1, m_p2, m_prev, m_h1, m_h2, m_f, m_run;
  bit           m_s, m_d, m_rise;
  int           m_idle;
  int           m_sum;
  int           win_q[$];
  logic [W-1:0] exp_level  = '0;
  logic         exp_valid  = 1'b0;
  logic         exp_locked = 1'b0;

  always @(posedge clk) begin
    if (!rstb) begin
      m_p1 = 0; m_p2 = 0; m_prev = 0; m_h1 = 0; m_h2 = 0; m_f = 0;
      m_run = 0; m_idle = 0; win_q.delete();
      exp_level = '0; exp_valid = 1'b0; exp_locked = 1'b0;
    end else begin
      m_s = m_p2;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
      if ((m_s == m_h1) && (m_s == m_h2)) m_f = m_s;
      m_d  = m_f;
      m_h2 = m_h1;
      m_h1 = m_s;
`else
      m_d = m_s;
`endif
      m_rise    = m_d && !m_prev;
      m_prev    = m_d;
      exp_valid = 1'b0;
      if (!m_run) begin
        if (m_rise) begin
          m_run = 1; m_idle = 0; win_q.delete(); win_q.push_back(1);
        end else if (m_idle == N - 1) begin
          m_run = 1; m_idle = 0; win_q.delete();
        end else begin
          m_idle++;
        end
      end else if (m_rise && (win_q.size() != 0)) begin
        exp_locked = 1'b0;
        win_q.delete();
        win_q.push_back(1);
      end else begin
        win_q.push_back(int'(m_d));
        if (win_q.size() == N) begin
          m_sum = 0;
          foreach (win_q[i]) m_sum += win_q[i];
          exp_level  = (m_sum > N - 1) ? W'(N - 1) : W'(m_sum);
          exp_valid  = 1'b1;
          exp_locked = 1'b1;
          win_q.delete();
        end
      end
      m_p2 = m_p1;
      m_p1 = pwm_in;
    end
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  // One cycle: step to the falling edge and compare all outputs to the model.
  task automatic tick();
    @(negedge clk);
    n_tests++;
    if ((valid !== exp_valid) || (locked !== exp_locked) || (level !== exp_level)) begin
      n_fail++;
      $display("FAIL cycle_cmp t=%0t valid=%0b exp=%0b locked=%0b exp=%0b level=%0d exp=%0d",
               $time, valid, exp_valid, locked, exp_locked, level, exp_level);
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic wait_valid(input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!valid && (cyc < max_cyc));
    if (!valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_valid: no valid within %0d cycles", max_cyc);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    int nv;
    bit dropped;

    // Reset state
    rstb   = 1'b0;
    drv_hi = 0;
    repeat (4) tick();
    check("reset_level", level, 0);
    check("reset_valid", valid, 0);
    check("reset_locked", locked, 0);
    check("reset_state", dbg_state, 0);

    // Constant low: 256-cycle timeout, then one full window
    rstb = 1'b1;
    wait_valid(700, cyc);
    check("low_first_latency", cyc, 512);
    check("low_level", level, 0);
    check("low_locked", locked, 1);
    wait_valid(300, cyc);
    check("low_period", cyc, 256);

    // Constant high: saturates to N-1
    rstb   = 1'b0;
    drv_hi = 256;
    tick();
    tick();
    rstb = 1'b1;
    wait_valid(700, cyc);
    check("high_first_latency", cyc, 258 + C_FILT_LAT);
    check("high_level", level, 255);
    wait_valid(300, cyc);
    check("high_period", cyc, 256);
    check("high_level2", level, 255);

    // Encoder level 127
    rstb   = 1'b0;
    drv_hi = 127;
    tick();
    rstb = 1'b1;
    wait_valid(800, cyc);
    check("enc127_level", level, 127);
    wait_valid(300, cyc);
    check("enc127_period", cyc, 256);
    check("enc127_level2", level, 127);
    check("enc127_locked", locked, 1);

    // One-cycle reset at window index ~100
    repeat (99) tick();
    rstb = 1'b0;
    tick();
    check("midrst_level", level, 0);
    check("midrst_valid", valid, 0);
    check("midrst_locked", locked, 0);
    rstb = 1'b1;
    wait_valid(800, cyc);
    check("midrst_resume_level", level, 127);
    check("midrst_resume_locked", locked, 1);

    // Level 63 then a 10-cycle phase jump
    drv_hi = 63;
    repeat (3) wait_valid(800, cyc);
    check("lvl63_level", level, 63);
    shift_cnt++;
    dropped = 0;
    for (int i = 0; i < 600 && !dropped; i++) begin
      tick();
      if (!locked) dropped = 1;
    end
    check("shift_unlock", dropped, 1);
    wait_valid(800, cyc);
    check("shift_relock_level", level, 63);
    check("shift_relock_locked", locked, 1);

    // Level 31 with 1-cycle glitches in the low phase
    drv_hi = 31;
    repeat (2) wait_valid(800, cyc);
    check("lvl31_level", level, 31);
    glitch_en = 1'b1;
    dropped = 0;
    nv = 0;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
    for (int i = 0; i < 700 && nv < 2; i++) begin
      tick();
      if (!locked) dropped = 1;
      if (valid) nv++;
    end
    check("glitch_valids", nv, 2);
    check("glitch_locked_held", dropped, 0);
    check("glitch_level", level, 31);
`else
    for (int i = 0; i < 700; i++) begin
      tick();
      if (!locked) dropped = 1;
    end
    check("glitch_realign", dropped, 1);
`endif
    glitch_en = 1'b0;

    // Randomized levels with occasional phase jumps and short resets
    for (int k = 0; k < 12; k++) begin
      drv_hi = $urandom_range(3, 253);
      if ($urandom_range(0, 3) == 0) shift_cnt++;
      if ($urandom_range(0, 4) == 0) begin
        rstb = 1'b0;
        tick();
        rstb = 1'b1;
      end
      repeat (3) wait_valid(1200, cyc);
      check("rand_level", level, drv_hi);
      check("rand_locked", locked, 1);
    end

    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
